// File: rtl/guia_1103_serializer.sv
// Parallel-to-serial converter feeding the serial "1010" detector: one WIDTH-bit word per
// valid/ready handshake, shifted out MSB- or LSB-first, with an optional idle gap between words.
module guia_1103_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       gap_q;
    logic             x_q;
    logic             x_valid_q;
    logic             done_q;
    logic             last_bit_s;
    logic             handshake_s;

    // Bit that leaves the word first, in the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    // Word with its head bit consumed; vacated positions fill with zero.
    function automatic logic [WIDTH-1:0] rest_bits(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return {w[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, w[WIDTH-1:1]};
        end
    endfunction

    assign last_bit_s  = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
    assign load_ready  = (state_q == ST_IDLE) || ((GAP_CYCLES == 0) && last_bit_s);
    assign handshake_s = load_valid && load_ready;
    assign busy        = (state_q != ST_IDLE);
    assign x           = x_q;
    assign x_valid     = x_valid_q;
    assign done        = done_q;

    // Serializer FSM: state, shift register, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            gap_q     <= 4'd0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (handshake_s) begin
                        shreg_q   <= rest_bits(din);
                        x_q       <= head_bit(din);
                        x_valid_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_SHIFT;
                    end else begin
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q != LAST_IDX) begin
                        shreg_q   <= rest_bits(shreg_q);
                        x_q       <= head_bit(shreg_q);
                        x_valid_q <= 1'b1;
                        cnt_q     <= cnt_q + CW'(1);
                        done_q    <= (cnt_q + CW'(1) == LAST_IDX);
                    end else if (GAP_CYCLES > 0) begin
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                        done_q    <= 1'b0;
                        gap_q     <= 4'd0;
                        state_q   <= ST_GAP;
                    end else if (handshake_s) begin
                        // Zero-gap reload: next word's first bit follows with no bubble.
                        shreg_q   <= rest_bits(din);
                        x_q       <= head_bit(din);
                        x_valid_q <= 1'b1;
                        done_q    <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                        done_q    <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    x_q       <= 1'b0;
                    x_valid_q <= 1'b0;
                    done_q    <= 1'b0;
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= 4'd0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    x_q       <= 1'b0;
                    x_valid_q <= 1'b0;
                    done_q    <= 1'b0;
                    cnt_q     <= '0;
                    gap_q     <= 4'd0;
                end
            endcase
        end
    end

endmodule
